ide_pio_sequencer: RTL

Single-channel ATA PIO register-access sequencer between the PDP-11 core's IDE register window and the external IDE bus (`ide_data_bus`, `ide_dior`, `ide_diow`, `ide_cs`, `ide_da`). It accepts one 16-bit register read or write at a time. It drives address/chip-select setup, the strobe pulse, hold and recovery with parameterised cycle counts, then returns read data and a one-cycle acknowledge. It serialises all CPU IDE accesses so the bench-side `$pli_ide` model and real drives see ATA-legal strobe timing.

---
 rtl/ide_pio_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ide_pio_sequencer.sv
// rtl/ide_pio_sequencer.sv - ATA PIO register-access sequencer with parameterised setup/pulse/hold/recovery
// One 16-bit register access at a time; every bus-side output comes straight from a flop.
module ide_pio_sequencer #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned PULSE_CYC   = 6,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [4:0]  i_addr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_ack,
  output logic        o_busy,
  inout  wire  [15:0] io_ide_data_bus,
  output logic        o_ide_dior,
  output logic        o_ide_diow,
  output logic [1:0]  o_ide_cs,
  output logic [2:0]  o_ide_da
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_RECOVER} state_t;

  localparam logic [3:0] L_SETUP   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] L_PULSE   = 4'(PULSE_CYC - 1);
  localparam logic [3:0] L_HOLD    = 4'(HOLD_CYC - 1);
  localparam logic [3:0] L_RECOVER = 4'(RECOVER_CYC - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        r_we;
  logic [4:0]  r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_ack;
  logic        r_busy;
  logic        r_dior;
  logic        r_diow;
  logic [1:0]  r_cs;
  logic [2:0]  r_da;
  logic        r_drive;

  logic        w_accept;
  logic        w_we_eff;
  logic [4:0]  w_addr_eff;
  logic        w_in_access;
  logic        w_ack_next;
  logic        w_busy_next;
  logic        w_dior_next;
  logic        w_diow_next;
  logic [1:0]  w_cs_next;
  logic [2:0]  w_da_next;
  logic        w_drive_next;

  assign w_accept   = (r_state == S_IDLE) && i_req;
  assign w_we_eff   = w_accept ? i_we : r_we;
  assign w_addr_eff = w_accept ? i_addr : r_addr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 5'b11000;
      r_wdata <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_state_next = S_SETUP;
          w_cnt_next   = L_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_PULSE;
          w_cnt_next   = L_PULSE;
        end
      end
      S_PULSE: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_HOLD;
          w_cnt_next   = L_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_RECOVER;
          w_cnt_next   = L_RECOVER;
        end
      end
      S_RECOVER: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_IDLE;
          w_cnt_next   = 4'd0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in flops aligned with the state change.
  always_comb begin
    w_in_access  = (w_state_next == S_SETUP) || (w_state_next == S_PULSE) || (w_state_next == S_HOLD);
    w_busy_next  = (w_state_next != S_IDLE);
    w_ack_next   = (w_state_next == S_RECOVER) && (r_state == S_HOLD);
    w_cs_next    = w_in_access ? w_addr_eff[4:3] : 2'b11;
    w_da_next    = w_in_access ? w_addr_eff[2:0] : 3'b000;
    w_dior_next  = !((w_state_next == S_PULSE) && !w_we_eff);
    w_diow_next  = !((w_state_next == S_PULSE) && w_we_eff);
    w_drive_next = w_in_access && w_we_eff;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_dior  <= 1'b1;
      r_diow  <= 1'b1;
      r_cs    <= 2'b11;
      r_da    <= 3'b000;
      r_drive <= 1'b0;
      r_rdata <= 16'h0000;
    end else begin
      r_ack   <= w_ack_next;
      r_busy  <= w_busy_next;
      r_dior  <= w_dior_next;
      r_diow  <= w_diow_next;
      r_cs    <= w_cs_next;
      r_da    <= w_da_next;
      r_drive <= w_drive_next;
      // Capture on the edge that ends the last strobe-low cycle, while the drive still holds data.
      if ((r_state == S_PULSE) && (r_cnt == 4'd0) && !r_we)
        r_rdata <= io_ide_data_bus;
    end
  end

  assign io_ide_data_bus = r_drive ? r_wdata : 16'hzzzz;
  assign o_rdata         = r_rdata;
  assign o_ack           = r_ack;
  assign o_busy          = r_busy;
  assign o_ide_dior      = r_dior;
  assign o_ide_diow      = r_diow;
  assign o_ide_cs        = r_cs;
  assign o_ide_da        = r_da;

endmodule
